// File: rtl/borrow_lookahead_subtractor_pipe_pkg.sv
// borrow_lookahead_subtractor_pipe_pkg: shared widths and active-width legality check
package borrow_lookahead_subtractor_pipe_pkg;
  localparam int W = 5;
  localparam int N_MIN = 2;
  localparam int N_MAX = 5;
  function automatic logic is_legal_width(input logic [2:0] n, input int lo = N_MIN, input int hi = N_MAX);
    return (int'(n) >= lo) && (int'(n) <= hi);
  endfunction
endpackage

// File: rtl/borrow_lookahead_unit.sv
// borrow_lookahead_unit: flattened sum-of-products borrow lookahead over the low n bits
module borrow_lookahead_unit
  import borrow_lookahead_subtractor_pipe_pkg::*;
#(
  parameter int WD = W
) (
  input  logic [WD-1:0] g_i,
  input  logic [WD-1:0] p_i,
  input  logic [WD-1:0] x_i,
  input  logic          bi_i,
  input  logic [2:0]    n_i,
  output logic [WD-1:0] diff_o,
  output logic          bo_o
);
  logic [WD:0] c;
  always_comb begin
    logic pp;
    logic acc;
    c = '0;
    c[0] = bi_i;
    diff_o = '0;
    for (int i = 0; i < WD; i++) begin
      pp = 1'b1;
      acc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (pp & g_i[j]);
        pp = pp & p_i[j];
      end
      c[i+1] = acc | (pp & bi_i);
    end
    for (int i = 0; i < WD; i++) diff_o[i] = (i < int'(n_i)) & (x_i[i] ^ c[i]);
    bo_o = (int'(n_i) <= WD) ? c[n_i] : 1'b0;
  end
endmodule

// File: rtl/borrow_lookahead_subtractor_pipe.sv
// borrow_lookahead_subtractor_pipe: two-stage valid/ready pipelined a - b - bi over n bits
module borrow_lookahead_subtractor_pipe #(
  parameter int W = borrow_lookahead_subtractor_pipe_pkg::W,
  parameter int N_MIN = borrow_lookahead_subtractor_pipe_pkg::N_MIN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   n,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] diff,
  output logic         bo,
  output logic         err,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] g_q, p_q, x_q, diff_q, diff_d, ud;
  logic [2:0]   n_q;
  logic         bi_q, err1_q, s1_valid_q, bo_q, bo_d, err_q, out_valid_q, ub, s1_adv, s2_adv;
  assign s2_adv = ~out_valid_q | out_ready;
  assign s1_adv = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  borrow_lookahead_unit #(.WD(W)) u_bla (
    .g_i(g_q), .p_i(p_q), .x_i(x_q), .bi_i(bi_q), .n_i(n_q), .diff_o(ud), .bo_o(ub)
  );
  always_comb begin
    diff_d = err1_q ? '0 : ud;
    bo_d = err1_q ? 1'b0 : ub;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q <= '0;
      bo_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (s1_adv && in_valid) begin
        g_q <= ~a & b;
        p_q <= ~(a ^ b);
        x_q <= a ^ b;
        bi_q <= bi;
        n_q <= n;
        err1_q <= ~borrow_lookahead_subtractor_pipe_pkg::is_legal_width(n, N_MIN, W);
      end
      if (s2_adv) out_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        diff_q <= diff_d;
        bo_q <= bo_d;
        err_q <= err1_q;
      end
    end
  end
  assign diff = diff_q;
  assign bo = bo_q;
  assign err = err_q;
  assign out_valid = out_valid_q;
endmodule
